// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int WIDTH_DEFAULT = 8;

   // The counter must hold WIDTH-1, so $clog2(WIDTH+1) bits covers every legal WIDTH.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; master drives operands, slave is the adder.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output a, b, in_valid, out_ready,
      input  in_ready, sum, carry, ovf, out_valid
   );

   modport slave (
      input  a, b, in_valid, out_ready,
      output in_ready, sum, carry, ovf, out_valid
   );
endinterface

// File: rtl/half_adder.sv
// Team half-adder cell: s = a ^ b, c = a & b.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: rtl/serial_fa_bit.sv
// Combinational full-adder slice: two half-adder cells plus an OR for carry-out.
module serial_fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a (a),
      .b (b),
      .s (s0),
      .c (c0)
   );

   half_adder u_ha1 (
      .a (s0),
      .b (cin),
      .s (s),
      .c (c1)
   );

   assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock with a registered carry.
// Define SERIAL_ADDER_OVF_EN to register signed overflow on ovf; otherwise ovf is tied low.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int CNT_W = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fa_s;
   logic             fa_cout;
   logic             last_bit;

   serial_fa_bit u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               sum_d   = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            // New sum bit enters at the MSB so the result ends up aligned after WIDTH shifts.
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            carry_d = fa_cout;
            if (last_bit) begin
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = carry_q ^ fa_cout;
`endif
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Handshake flags decode straight from the state register.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.carry     = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf       = ovf_q;
`else
   assign bus.ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: vector table through a scoreboard plus stall, reset and WIDTH=1 sequences.
module tb_serial_adder;
   localparam int W = 8;
`ifdef SERIAL_ADDER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(W)) bus ();
   serial_adder_if #(.WIDTH(1)) bus1 ();

   serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       c;
      logic       v;
   } vec_t;

   typedef struct packed {
      logic [7:0] sum;
      logic       c;
      logic       v;
   } exp_t;

   vec_t tbl[11];
   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es,
                          input logic ec, input logic ev, input int stall,
                          input bit hold_valid, input string nm);
      int   lat;
      exp_t e;
      lat = 0;
      while (!bus.in_ready && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({nm, " in_ready"}, bus.in_ready, 1);
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      bus.out_ready = (stall == 0);
      sb.push_back('{sum: es, c: ec, v: (OVF_EN ? ev : 1'b0)});
      @(posedge clk);
      #1;
      if (!hold_valid) bus.in_valid = 1'b0;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      lat = 0;
      @(negedge clk);
      while (!bus.out_valid && lat < 200) begin
         lat++;
         if (hold_valid) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check({nm, " latency"}, lat, W);
      for (int i = 0; i < stall; i++) begin
         check({nm, " stall out_valid"}, bus.out_valid, 1);
         check({nm, " stall in_ready"}, bus.in_ready, 0);
         check({nm, " stall sum"}, bus.sum, es);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      if (sb.size() == 0) begin
         check({nm, " scoreboard empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         check({nm, " out_valid"}, bus.out_valid, 1);
         check({nm, " sum"}, bus.sum, e.sum);
         check({nm, " carry"}, bus.carry, e.c);
         check({nm, " ovf"}, bus.ovf, e.v);
      end
      @(negedge clk);
      check({nm, " out_valid drop"}, bus.out_valid, 0);
      check({nm, " in_ready back"}, bus.in_ready, 1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
      tbl[1]  = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      tbl[2]  = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      tbl[3]  = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      tbl[4]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[5]  = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
      tbl[6]  = '{8'hC3, 8'h3C, 8'hFF, 1'b0, 1'b0};
      tbl[7]  = '{8'h80, 8'h7F, 8'hFF, 1'b0, 1'b0};
      tbl[8]  = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1};
      tbl[9]  = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
      tbl[10] = '{8'h96, 8'h69, 8'hFF, 1'b0, 1'b0};

      bus.a = '0; bus.b = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus1.a = '0; bus1.b = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("reset in_ready", bus.in_ready, 1);
      check("reset out_valid", bus.out_valid, 0);
      check("reset sum", bus.sum, 0);
      check("reset carry", bus.carry, 0);
      check("reset ovf", bus.ovf, 0);
      check("reset w1 in_ready", bus1.in_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++)
         run_txn(tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].c, tbl[i].v, 0, 1'b0, $sformatf("vec%0d", i));

      run_txn(8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 5, 1'b0, "stall");
      run_txn(8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 0, 1'b1, "hold_valid");

      // Reset during the 4th RUN cycle of 0xAA+0x55.
      bus.a = 8'hAA; bus.b = 8'h55; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("midrun out_valid", bus.out_valid, 0);
      check("midrun in_ready", bus.in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("rst in_ready", bus.in_ready, 1);
      check("rst out_valid", bus.out_valid, 0);
      check("rst sum", bus.sum, 0);
      check("rst carry", bus.carry, 0);
      check("rst ovf", bus.ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post rst out_valid", bus.out_valid, 0);
      run_txn(8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b0, "after_rst");

      // WIDTH=1 instance: 1+1 gives sum 0, carry 1 after one cycle.
      bus1.a = 1'b1; bus1.b = 1'b1; bus1.in_valid = 1'b1;
      @(posedge clk);
      #1 bus1.in_valid = 1'b0;
      @(negedge clk);
      check("w1 out_valid early", bus1.out_valid, 0);
      @(negedge clk);
      check("w1 out_valid", bus1.out_valid, 1);
      check("w1 sum", bus1.sum, 0);
      check("w1 carry", bus1.carry, 1);
      check("w1 ovf", bus1.ovf, OVF_EN);
      @(negedge clk);
      check("w1 in_ready back", bus1.in_ready, 1);
      check("w1 out_valid drop", bus1.out_valid, 0);

      check("scoreboard drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
